// File: rtl/mux_scan_sequencer.sv
// Scanned reader for a 4-to-1 mux: steps the selects, waits SETTLE cycles per
// channel, samples the mux output and hands the 4-bit word over valid/ready.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mux_out,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [7:0] scan_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_sel;
  logic [1:0]  w_sel_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [3:0]  r_cap;
  logic [3:0]  w_cap_nxt;
  logic [3:0]  r_data;
  logic [3:0]  w_data_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        r_busy;
  logic        w_busy_nxt;
  logic [7:0]  r_count;
  logic [7:0]  w_count_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_cap   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cap   <= w_cap_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_cap_nxt   = r_cap;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_count_nxt = r_count;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SCAN;
          w_sel_nxt   = '0;
          w_cnt_nxt   = CNT_LOAD;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          // channel sel lands in bit 3-sel, i.e. the bitwise inverse of sel
          w_cap_nxt[~r_sel] = mux_out;
          if (r_sel != 2'd3) begin
            w_sel_nxt = r_sel + 2'd1;
            w_cnt_nxt = CNT_LOAD;
          end else begin
            w_data_nxt  = {r_cap[3:1], mux_out};
            w_valid_nxt = 1'b1;
            w_sel_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_valid_nxt = 1'b0;
          w_count_nxt = r_count + 8'd1;
          if (start) begin
            w_state_nxt = ST_SCAN;
            w_sel_nxt   = '0;
            w_cnt_nxt   = CNT_LOAD;
            w_busy_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign s0         = r_sel[1];
  assign s1         = r_sel[0];
  assign busy       = r_busy;
  assign out_valid  = r_valid;
  assign out_data   = r_data;
  assign scan_count = r_count;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (SETTLE=2 and SETTLE=1), each
// reading a behavioural 4-to-1 mux; expected words kept in per-instance queues.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_start, a_mux_out, a_s0, a_s1, a_busy, a_valid, a_ready;
  logic [3:0] a_data, a_in;
  logic [7:0] a_count;
  logic       b_start, b_mux_out, b_s0, b_s1, b_busy, b_valid, b_ready;
  logic [3:0] b_data, b_in;
  logic [7:0] b_count;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] q_a[$];
  logic [3:0] q_b[$];
  logic [7:0] cnt_a, cnt_b;

  // mux model: select 00 routes i0, which is bit 3 of the input word
  assign a_mux_out = a_in[2'd3 - {a_s0, a_s1}];
  assign b_mux_out = b_in[2'd3 - {b_s0, b_s1}];

  mux_scan_sequencer #(.SETTLE(2)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .mux_out(a_mux_out),
    .s0(a_s0), .s1(a_s1), .busy(a_busy), .out_valid(a_valid),
    .out_ready(a_ready), .out_data(a_data), .scan_count(a_count)
  );

  mux_scan_sequencer #(.SETTLE(1)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .mux_out(b_mux_out),
    .s0(b_s0), .s1(b_s1), .busy(b_busy), .out_valid(b_valid),
    .out_ready(b_ready), .out_data(b_data), .scan_count(b_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts a scan on instance A and waits (bounded) for out_valid.
  task automatic run_a(input logic [3:0] w);
    a_in = w;
    a_start = 1'b1;
    q_a.push_back(w);
    tick;
    a_start = 1'b0;
    for (int i = 0; i < 20 && !a_valid; i++) tick;
    checks++;
    if (a_valid !== 1'b1) begin
      failures++;
      $display("FAIL run_a_timeout out_valid=%b required=1", a_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if ({a_s0, a_s1, a_busy, a_valid, a_data, a_count} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_a s=%b%b busy=%b valid=%b data=%b count=%0d required all zero",
               a_s0, a_s1, a_busy, a_valid, a_data, a_count);
    end
    checks++;
    if ({b_s0, b_s1, b_busy, b_valid, b_data, b_count} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_b s=%b%b busy=%b valid=%b data=%b count=%0d required all zero",
               b_s0, b_s1, b_busy, b_valid, b_data, b_count);
    end
    rst = 1'b0;
    cnt_a = 8'd0;
    cnt_b = 8'd0;
    tick;
  endtask

  task automatic test_basic_scan;
    logic [3:0] exp_w;
    a_in = 4'b1010;
    a_start = 1'b1;
    q_a.push_back(4'b1010);
    tick;
    a_start = 1'b0;
    checks++;
    if (a_busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got=%b required=1", a_busy);
    end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick;
      checks++;
      if ({a_s0, a_s1} !== 2'(k / 2) || a_valid !== 1'b0) begin
        failures++;
        $display("FAIL basic_sel step=%0d sel=%b%b valid=%b required sel=%b valid=0",
                 k, a_s0, a_s1, a_valid, 2'(k / 2));
      end
    end
    tick;
    checks++;
    if (a_valid !== 1'b1 || a_busy !== 1'b0 || {a_s0, a_s1} !== 2'b00) begin
      failures++;
      $display("FAIL basic_done valid=%b busy=%b sel=%b%b required valid=1 busy=0 sel=00",
               a_valid, a_busy, a_s0, a_s1);
    end
    exp_w = q_a.pop_front();
    checks++;
    if (a_data !== exp_w) begin
      failures++;
      $display("FAIL basic_data got=%b required=%b", a_data, exp_w);
    end
    a_ready = 1'b1;
    tick;
    a_ready = 1'b0;
    cnt_a++;
    checks++;
    if (a_valid !== 1'b0 || a_count !== cnt_a) begin
      failures++;
      $display("FAIL basic_accept valid=%b count=%0d required valid=0 count=%0d",
               a_valid, a_count, cnt_a);
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] exp_w;
    run_a(4'b1010);
    exp_w = q_a.pop_front();
    a_in = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      a_start = (k % 2 == 0);
      tick;
      checks++;
      if (a_valid !== 1'b1 || a_data !== exp_w || {a_s0, a_s1} !== 2'b00 || a_busy !== 1'b0) begin
        failures++;
        $display("FAIL backpressure cyc=%0d valid=%b data=%b sel=%b%b busy=%b required 1 %b 00 0",
                 k, a_valid, a_data, a_s0, a_s1, a_busy, exp_w);
      end
    end
    a_start = 1'b0;
    a_ready = 1'b1;
    tick;
    a_ready = 1'b0;
    cnt_a++;
    checks++;
    if (a_valid !== 1'b0 || a_count !== cnt_a || a_busy !== 1'b0 || a_data !== exp_w) begin
      failures++;
      $display("FAIL backpressure_release valid=%b count=%0d busy=%b data=%b required 0 %0d 0 %b",
               a_valid, a_count, a_busy, a_data, cnt_a, exp_w);
    end
  endtask

  task automatic test_start_ignored;
    logic [3:0] exp_w;
    a_in = 4'b0101;
    a_start = 1'b1;
    q_a.push_back(4'b0101);
    tick;
    for (int k = 1; k < 8; k++) begin
      tick;
      checks++;
      if (a_valid !== 1'b0 || a_busy !== 1'b1 || {a_s0, a_s1} !== 2'(k / 2)) begin
        failures++;
        $display("FAIL start_ignored step=%0d valid=%b busy=%b sel=%b%b required 0 1 %b",
                 k, a_valid, a_busy, a_s0, a_s1, 2'(k / 2));
      end
    end
    tick;
    exp_w = q_a.pop_front();
    checks++;
    if (a_valid !== 1'b1 || a_data !== exp_w) begin
      failures++;
      $display("FAIL start_ignored_done valid=%b data=%b required 1 %b", a_valid, a_data, exp_w);
    end
    a_start = 1'b0;
    a_ready = 1'b1;
    tick;
    a_ready = 1'b0;
    cnt_a++;
    checks++;
    if (a_count !== cnt_a || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL start_ignored_accept count=%0d busy=%b required %0d 0", a_count, a_busy, cnt_a);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_w;
    b_in = 4'b0110;
    b_start = 1'b1;
    q_b.push_back(4'b0110);
    tick;
    b_start = 1'b0;
    for (int k = 0; k < 3; k++) tick;
    checks++;
    if (b_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_early valid=%b required=0", b_valid);
    end
    tick;
    exp_w = q_b.pop_front();
    checks++;
    if (b_valid !== 1'b1 || b_data !== exp_w) begin
      failures++;
      $display("FAIL b2b_first valid=%b data=%b required 1 %b", b_valid, b_data, exp_w);
    end
    b_in = 4'b1001;
    b_ready = 1'b1;
    b_start = 1'b1;
    q_b.push_back(4'b1001);
    tick;
    b_ready = 1'b0;
    b_start = 1'b0;
    cnt_b++;
    checks++;
    if (b_busy !== 1'b1 || b_valid !== 1'b0 || b_count !== cnt_b || {b_s0, b_s1} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_restart busy=%b valid=%b count=%0d sel=%b%b required 1 0 %0d 00",
               b_busy, b_valid, b_count, b_s0, b_s1, cnt_b);
    end
    for (int k = 0; k < 3; k++) tick;
    checks++;
    if (b_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_early valid=%b required=0", b_valid);
    end
    tick;
    exp_w = q_b.pop_front();
    checks++;
    if (b_valid !== 1'b1 || b_data !== exp_w) begin
      failures++;
      $display("FAIL b2b_second valid=%b data=%b required 1 %b", b_valid, b_data, exp_w);
    end
    b_ready = 1'b1;
    tick;
    b_ready = 1'b0;
    cnt_b++;
  endtask

  task automatic test_reset_midscan;
    logic [3:0] exp_w;
    a_in = 4'b1010;
    a_start = 1'b1;
    q_a.push_back(4'b1010);
    tick;
    a_start = 1'b0;
    for (int k = 0; k < 4; k++) tick;
    checks++;
    if ({a_s0, a_s1} !== 2'b10) begin
      failures++;
      $display("FAIL midscan_sel sel=%b%b required=10", a_s0, a_s1);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({a_s0, a_s1, a_busy, a_valid, a_data, a_count} !== 16'h0000) begin
      failures++;
      $display("FAIL midscan_reset s=%b%b busy=%b valid=%b data=%b count=%0d required all zero",
               a_s0, a_s1, a_busy, a_valid, a_data, a_count);
    end
    q_a.delete();
    cnt_a = 8'd0;
    cnt_b = 8'd0;
    tick;
    rst = 1'b0;
    tick;
    run_a(4'b1111);
    exp_w = q_a.pop_front();
    checks++;
    if (a_data !== exp_w) begin
      failures++;
      $display("FAIL midscan_rescan data=%b required=%b", a_data, exp_w);
    end
    a_ready = 1'b1;
    tick;
    a_ready = 1'b0;
    cnt_a++;
    checks++;
    if (a_count !== cnt_a) begin
      failures++;
      $display("FAIL midscan_count count=%0d required=%0d", a_count, cnt_a);
    end
  endtask

  task automatic test_counter_wrap;
    logic [3:0] w;
    logic [3:0] exp_w;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    cnt_a = 8'd0;
    cnt_b = 8'd0;
    tick;
    for (int i = 0; i < 256; i++) begin
      w = 4'($urandom_range(0, 15));
      b_in = w;
      b_start = 1'b1;
      q_b.push_back(w);
      tick;
      b_start = 1'b0;
      for (int j = 0; j < 10 && !b_valid; j++) tick;
      exp_w = q_b.pop_front();
      checks++;
      if (b_valid !== 1'b1 || b_data !== exp_w) begin
        failures++;
        $display("FAIL wrap_data scan=%0d valid=%b data=%b required 1 %b", i, b_valid, b_data, exp_w);
      end
      b_ready = 1'b1;
      tick;
      b_ready = 1'b0;
      cnt_b++;
      checks++;
      if (b_count !== cnt_b) begin
        failures++;
        $display("FAIL wrap_count scan=%0d count=%0d required=%0d", i, b_count, cnt_b);
      end
      if (i == 254) begin
        checks++;
        if (b_count !== 8'd255) begin
          failures++;
          $display("FAIL wrap_255 count=%0d required=255", b_count);
        end
      end
    end
    checks++;
    if (b_count !== 8'd0) begin
      failures++;
      $display("FAIL wrap_zero count=%0d required=0", b_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_ready = 1'b0; a_in = 4'b0000;
    b_start = 1'b0; b_ready = 1'b0; b_in = 4'b0000;
    cnt_a = 8'd0;
    cnt_b = 8'd0;
    test_reset;
    test_basic_scan;
    test_backpressure;
    test_start_ignored;
    test_back_to_back;
    test_reset_midscan;
    test_counter_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
